// File: rtl/branch_predict_resolve_pkg.sv
// branch_predict_resolve_pkg: shared encodings and helpers for the branch unit
package branch_predict_resolve_pkg;

    typedef enum logic [1:0] {
        BR_NE = 2'b00,
        BR_LT = 2'b01,
        BR_EQ = 2'b10,
        BR_GE = 2'b11
    } br_type_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Weakly not-taken: one below the midpoint, 0 for single-bit counters.
    function automatic int CTR_RESET_VAL(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

endpackage

// File: rtl/branch_predict_resolve_sat_counter.sv
// sat_counter: up/down counter that saturates at both ends
module sat_counter
    import branch_predict_resolve_pkg::*;
#(
    parameter int CTR_BITS = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    input  logic                up,
    output logic [CTR_BITS-1:0] value
);

    logic [CTR_BITS-1:0] value_q, value_d;

    // Step toward the requested direction unless already pinned at that end.
    always_comb
        value_d = !en ? value_q : up ? (&value_q ? value_q : value_q + 1'b1) : (|value_q ? value_q - 1'b1 : value_q);

    // Counter state; reset restores the weakly not-taken value.
    always_ff @(posedge clock)
        value_q <= reset ? CTR_BITS'(CTR_RESET_VAL(CTR_BITS)) : value_d;

    assign value = value_q;

endmodule

// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: X-stage branch resolution with BHT prediction and registered redirect
module branch_predict_resolve
    import branch_predict_resolve_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CTR_BITS    = 2,
    parameter int CNT_BITS    = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              fetchPc,
    output logic                          predTaken,
    input  logic                          resolveValid,
    input  logic [1:0]                    brType,
    input  logic                          iNE,
    input  logic                          iLT,
    input  logic [WIDTH-1:0]              pcX,
    input  logic [WIDTH-1:0]              signExtendedImm,
    input  logic                          predTakenX,
    input  logic [clog2(BHT_ENTRIES)-1:0] idxX,
    output logic                          redirectValid,
    output logic [WIDTH-1:0]              redirectPc,
    output logic                          actualTaken,
    output logic [CNT_BITS-1:0]           mispredictCount
);

    localparam int IDX_BITS = clog2(BHT_ENTRIES);

    logic [CTR_BITS-1:0] ctr [BHT_ENTRIES];
    logic [CTR_BITS-1:0] cur_ctr, upd_ctr;
    logic [IDX_BITS-1:0] fetch_idx;
    logic [WIDTH-1:0]    target;
    logic                taken, mispredict;
    logic                redirect_valid_q, redirect_valid_d;
    logic [WIDTH-1:0]    redirect_pc_q, redirect_pc_d;
    logic                actual_taken_q, actual_taken_d;
    logic [CNT_BITS-1:0] count_q, count_d;

    for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
        sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
            .clock (clock),
            .reset (reset),
            .en    (resolveValid && idxX == IDX_BITS'(i)),
            .up    (taken),
            .value (ctr[i])
        );
    end

    // Resolve direction, target and the prediction read with write-through bypass.
    always_comb begin
        taken      = brType == BR_NE ? iNE : brType == BR_LT ? iLT : brType == BR_EQ ? ~iNE : ~iLT;
        target     = pcX + signExtendedImm;
        mispredict = resolveValid && (taken != predTakenX);
        fetch_idx  = fetchPc[IDX_BITS-1:0];
        cur_ctr    = ctr[idxX];
        upd_ctr    = taken ? (&cur_ctr ? cur_ctr : cur_ctr + 1'b1) : (|cur_ctr ? cur_ctr - 1'b1 : cur_ctr);
        predTaken  = (resolveValid && !reset && fetch_idx == idxX) ? upd_ctr[CTR_BITS-1] : ctr[fetch_idx][CTR_BITS-1];
    end

    // Next-state for the redirect outputs and the saturating mispredict counter.
    always_comb begin
        redirect_valid_d = mispredict;
        redirect_pc_d    = resolveValid ? (taken ? target : pcX) : redirect_pc_q;
        actual_taken_d   = resolveValid ? taken : actual_taken_q;
        count_d          = (mispredict && !(&count_q)) ? count_q + 1'b1 : count_q;
    end

    // Registered redirect state; reset also drops any branch sitting in X.
    always_ff @(posedge clock) begin
        if (reset) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            actual_taken_q   <= 1'b0;
            count_q          <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            actual_taken_q   <= actual_taken_d;
            count_q          <= count_d;
        end
    end

    assign redirectValid   = redirect_valid_q;
    assign redirectPc      = redirect_pc_q;
    assign actualTaken     = actual_taken_q;
    assign mispredictCount = count_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb_branch_predict_resolve: scoreboard bench for the branch resolve unit
module tb_branch_predict_resolve;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetchPc;
    logic        predTaken;
    logic        resolveValid;
    logic [1:0]  brType;
    logic        iNE, iLT;
    logic [31:0] pcX, signExtendedImm;
    logic        predTakenX;
    logic [3:0]  idxX;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        actualTaken;
    logic [1:0]  mispredictCount;

    branch_predict_resolve #(
        .WIDTH(32), .BHT_ENTRIES(16), .CTR_BITS(2), .CNT_BITS(2)
    ) dut (
        .clock(clk), .reset(reset), .fetchPc(fetchPc), .predTaken(predTaken),
        .resolveValid(resolveValid), .brType(brType), .iNE(iNE), .iLT(iLT),
        .pcX(pcX), .signExtendedImm(signExtendedImm), .predTakenX(predTakenX),
        .idxX(idxX), .redirectValid(redirectValid), .redirectPc(redirectPc),
        .actualTaken(actualTaken), .mispredictCount(mispredictCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        t;
        logic [1:0]  c;
    } exp_t;

    exp_t        sb[$];
    int          mb[16];
    logic [31:0] pc_m;
    logic        tk_m;
    int          cnt_m;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: no expected entry at %0t", $time);
        end else begin
            e = sb.pop_front();
            check("redirectValid", redirectValid, e.v);
            check("redirectPc", redirectPc, e.pc);
            check("actualTaken", actualTaken, e.t);
            check("mispredictCount", mispredictCount, e.c);
        end
    endtask

    function automatic logic dir(input logic [1:0] bt, input logic ne, input logic lt);
        return bt == 2'd0 ? ne : bt == 2'd1 ? lt : bt == 2'd2 ? !ne : !lt;
    endfunction

    task automatic drive(input logic rv, input logic [1:0] bt, input logic ne, input logic lt,
                         input logic [31:0] pcx, input logic [31:0] imm, input logic ptx,
                         input logic [3:0] idx, input logic [31:0] fpc);
        logic tk, mis;
        int   nv;
        exp_t e;
        resolveValid = rv; brType = bt; iNE = ne; iLT = lt; pcX = pcx;
        signExtendedImm = imm; predTakenX = ptx; idxX = idx; fetchPc = fpc;
        #1;
        tk = dir(bt, ne, lt);
        nv = tk ? (mb[idx] == 3 ? 3 : mb[idx] + 1) : (mb[idx] == 0 ? 0 : mb[idx] - 1);
        check("predTaken", predTaken, (rv && fpc[3:0] == idx) ? nv[1] : mb[fpc[3:0]][1]);
        mis = rv && (tk != ptx);
        if (rv) begin
            mb[idx] = nv;
            pc_m = tk ? pcx + imm : pcx;
            tk_m = tk;
        end
        if (mis && cnt_m != 3) cnt_m++;
        e = '{mis, pc_m, tk_m, 2'(cnt_m)};
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        compare_out();
    endtask

    task automatic do_reset(input logic rv, input logic [3:0] idx);
        exp_t e;
        reset = 1'b1; resolveValid = rv; brType = 2'd0; iNE = 1'b1; iLT = 1'b0;
        pcX = 32'h40; signExtendedImm = 32'h8; predTakenX = 1'b0; idxX = idx; fetchPc = 32'h0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) mb[i] = 1;
        pc_m = '0; tk_m = 1'b0; cnt_m = 0;
        e = '{1'b0, 32'h0, 1'b0, 2'd0};
        sb.push_back(e);
        compare_out();
    endtask

    initial begin
        logic tk;
        reset = 1'b1;
        @(negedge clk);
        do_reset(1'b0, 4'd0);

        // basic mispredict, then entry 5 reads taken
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'd5);
        drive(1, 0, 1, 0, 32'd6, 32'd10, 0, 4'd5, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'd5);

        // every mode against every flag pair, correctly predicted
        for (int bt = 0; bt < 4; bt++)
            for (int f = 0; f < 4; f++) begin
                tk = dir(2'(bt), f[1], f[0]);
                drive(1, 2'(bt), f[1], f[0], $urandom, $urandom, tk, 4'(8 + bt), 32'd1);
            end

        // saturation on entry 3
        for (int i = 0; i < 5; i++) drive(1, 0, 1, 0, 32'h100, 32'h4, 1, 4'd3, 32'd3);
        drive(1, 0, 0, 0, 32'h100, 32'h4, 0, 4'd3, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'd3);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 32'h100, 32'h4, 0, 4'd3, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'd3);

        // write-through bypass on entry 7 from the reset value
        drive(1, 2'd3, 0, 0, 32'h200, 32'h10, 1, 4'd7, 32'h17);

        // target wraps past the top of the address space
        drive(1, 0, 1, 0, 32'hFFFF_FFFE, 32'd4, 0, 4'd2, 32'd0);

        // reset swallows a mispredicting branch in X
        do_reset(1'b1, 4'd5);
        for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 32'(i));

        // mispredict counter pins at all-ones
        for (int i = 0; i < 5; i++) drive(1, 2'd2, 0, 0, 32'h300, 32'h20, 0, 4'(12 + i % 2), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'd12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
